interval_timer_datapath: RTL and testbench

//  Status-generating datapath directly upstream of the traffic-light phase controller.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/car_debounce.sv | 52 +++++
 rtl/interval_timer_datapath.sv | 90 +++++++++
 tb/tb_interval_timer_datapath.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared interval-select codes and phase-flag bundle for the traffic-light controller and its datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_pkg;

    // Interval-select codes driven by the phase controller on s_IC
    typedef logic [1:0] ic_sel_t;

    localparam ic_sel_t IC_YEL = 2'b00;  // yellow
    localparam ic_sel_t IC_RR  = 2'b01;  // all-red clearance (RR1 and RR2 share this code)
    localparam ic_sel_t IC_NSG = 2'b10;  // north-south green
    localparam ic_sel_t IC_EWG = 2'b11;  // east-west green

    // Phase-exit flags the controller branches on
    typedef struct packed {
        logic not_r;      // all-red clearance elapsed
        logic c_and_l;    // N-S green may end
        logic en_s;       // yellow elapsed
        logic l_or_notc;  // E-W green may end
    } phase_flags_t;

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for the E-W car sensor.
// Latency: raw change to dout change is 2+DEB_CYC cycles.
// Backpressure: none; free-running sampler.
module car_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Counter only needs to reach DEB_CYC-1; the toggle happens on that cycle
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_LIM = DW'(DEB_CYC - 1);

    logic          sync_a_q;
    logic          sync_b_q;
    logic          car_q;
    logic [DW-1:0] deb_cnt_q;

    // Metastability guard: the sensor is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q <= 1'b0;
            sync_b_q <= 1'b0;
        end else begin
            sync_a_q <= din;
            sync_b_q <= sync_a_q;
        end
    end

    // Flip car_q only after DEB_CYC consecutive disagreeing samples; any agreeing sample restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            car_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else if (sync_b_q != car_q) begin
            if (deb_cnt_q == DEB_LIM) begin
                car_q     <= sync_b_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_q <= '0;
        end
    end

    assign dout = car_q;

endmodule

// File: rtl/interval_timer_datapath.sv
// Phase interval counter plus debounced car flag, decoded into the four phase-exit flags for the controller.
// Latency: s_IC change sampled at the next edge clears the counter; flags are decoded from registers only.
// Backpressure: none; en_IC qualifies s_IC and the counter always advances (saturating).
module interval_timer_datapath
    import traffic_pkg::*;
#(
    parameter int CW       = 8,
    parameter int YEL_CYC  = 4,
    parameter int RR_CYC   = 2,
    parameter int LONG_CYC = 16,
    parameter int DEB_CYC  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] s_IC,
    input  logic       en_IC,
    input  logic       car_e_raw,
    output logic       not_r,
    output logic       c_and_l,
    output logic       en_s,
    output logic       l_or_notc
);

    localparam int CNT_TOP = (1 << CW) - 1;

    // Elaboration-time legality of the interval parameters
    if (YEL_CYC < 1 || YEL_CYC > CNT_TOP) begin : g_bad_yel
        $error("YEL_CYC out of range for CW");
    end
    if (RR_CYC < 1 || RR_CYC > CNT_TOP) begin : g_bad_rr
        $error("RR_CYC out of range for CW");
    end
    if (LONG_CYC < 1 || LONG_CYC > CNT_TOP) begin : g_bad_long
        $error("LONG_CYC out of range for CW");
    end
    if (DEB_CYC < 1) begin : g_bad_deb
        $error("DEB_CYC must be at least 1");
    end

    // A flag asserts once the counter has reached interval-1
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] YEL_LIM  = CW'(YEL_CYC - 1);
    localparam logic [CW-1:0] RR_LIM   = CW'(RR_CYC - 1);
    localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYC - 1);

    ic_sel_t      sel_q;
    logic [CW-1:0] cnt_q;
    logic          car_q;
    phase_flags_t  flags;

    car_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_car_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (car_e_raw),
        .dout (car_q)
    );

    // Track the active interval; a new code restarts the count, a repeated code lets it run on and saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= IC_RR;
            cnt_q <= '0;
        end else if (en_IC && (s_IC != sel_q)) begin
            sel_q <= s_IC;
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Decode exit flags from registered state only, each gated by its own phase so a stale flag cannot leak across
    always_comb begin
        flags = '0;
        case (sel_q)
            IC_YEL: flags.en_s      = (cnt_q >= YEL_LIM);
            IC_RR:  flags.not_r     = (cnt_q >= RR_LIM);
            IC_NSG: flags.c_and_l   = car_q && (cnt_q >= LONG_LIM);
            IC_EWG: flags.l_or_notc = (cnt_q >= LONG_LIM) || !car_q;
            default: flags = '0;
        endcase
    end

    assign not_r     = flags.not_r;
    assign c_and_l   = flags.c_and_l;
    assign en_s      = flags.en_s;
    assign l_or_notc = flags.l_or_notc;

endmodule

// File: tb/tb_interval_timer_datapath.sv
module tb_interval_timer_datapath;

    logic       clk;
    logic       rst;
    logic [1:0] s_IC;
    logic       en_IC;
    logic       car_e_raw;
    logic       not_r;
    logic       c_and_l;
    logic       en_s;
    logic       l_or_notc;

    int n_checks = 0;
    int n_fail   = 0;

    interval_timer_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .s_IC      (s_IC),
        .en_IC     (en_IC),
        .car_e_raw (car_e_raw),
        .not_r     (not_r),
        .c_and_l   (c_and_l),
        .en_s      (en_s),
        .l_or_notc (l_or_notc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the datapath, advanced on every rising edge
    typedef struct {
        logic [3:0] flags;  // {not_r, c_and_l, en_s, l_or_notc}
        logic [7:0] cnt;
        logic [1:0] sel;
        logic       car;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] m_sel;
    int         m_cnt;
    logic       m_s1, m_s2, m_car;
    int         m_deb;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_sel = 2'b01; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_car = 0; m_deb = 0;
        end else begin
            if (en_IC && s_IC != m_sel) begin
                m_sel = s_IC;
                m_cnt = 0;
            end else if (m_cnt < 255) begin
                m_cnt = m_cnt + 1;
            end
            if (m_s2 != m_car) begin
                m_deb = m_deb + 1;
                if (m_deb == 3) begin
                    m_car = m_s2;
                    m_deb = 0;
                end
            end else begin
                m_deb = 0;
            end
            m_s2 = m_s1;
            m_s1 = car_e_raw;
        end
        e.flags[3] = (m_sel == 2'b01) && (m_cnt >= 1);
        e.flags[2] = (m_sel == 2'b10) && m_car && (m_cnt >= 15);
        e.flags[1] = (m_sel == 2'b00) && (m_cnt >= 3);
        e.flags[0] = (m_sel == 2'b11) && ((m_cnt >= 15) || !m_car);
        e.cnt = 8'(m_cnt);
        e.sel = m_sel;
        e.car = m_car;
        exp_q.push_back(e);
    end

    // Compare DUT against the oldest expectation, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_flags", 32'({not_r, c_and_l, en_s, l_or_notc}), 32'(e.flags));
            chk("sb_cnt",   32'(dut.cnt_q), 32'(e.cnt));
            chk("sb_sel",   32'(dut.sel_q), 32'(e.sel));
            chk("sb_car",   32'(dut.car_q), 32'(e.car));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_IC = 2'b01; en_IC = 1'b1; car_e_raw = 1'b0;

        // 1: reset, then all-red timing from reset
        cyc(); cyc();
        @(negedge clk);
        chk("t1_rst_flags", 32'({not_r, c_and_l, en_s, l_or_notc}), 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_first_cyc_flags", 32'({not_r, c_and_l, en_s, l_or_notc}), 32'd0);
        cyc();
        @(negedge clk);
        chk("t1_not_r_rise", 32'(not_r), 32'd1);

        // 2: yellow
        s_IC = 2'b00;
        cyc();
        @(negedge clk);
        chk("t2_not_r_drop", 32'(not_r), 32'd0);
        chk("t2_cnt_clear", 32'(dut.cnt_q), 32'd0);
        chk("t2_en_s_c0", 32'(en_s), 32'd0);
        cyc(); cyc();
        @(negedge clk);
        chk("t2_en_s_c2", 32'(en_s), 32'd0);
        cyc();
        @(negedge clk);
        chk("t2_en_s_c3", 32'(en_s), 32'd1);

        // 3: N-S green with a car waiting
        s_IC = 2'b10; car_e_raw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            @(negedge clk);
            chk("t3_c_and_l_car", 32'(c_and_l), (i == 15) ? 32'd1 : 32'd0);
        end
        s_IC = 2'b01; car_e_raw = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        chk("t3_car_cleared", 32'(dut.car_q), 32'd0);
        s_IC = 2'b10;
        for (int i = 0; i < 100; i++) begin
            cyc();
            @(negedge clk);
            if (i % 25 == 0 || i == 99) chk("t3_c_and_l_nocar", 32'(c_and_l), 32'd0);
        end

        // 4: E-W green without and with a car
        s_IC = 2'b11;
        cyc();
        @(negedge clk);
        chk("t4_l_or_notc_nocar", 32'(l_or_notc), 32'd1);
        s_IC = 2'b01; car_e_raw = 1'b1;
        repeat (8) cyc();
        @(negedge clk);
        s_IC = 2'b11;
        for (int i = 0; i < 16; i++) begin
            cyc();
            @(negedge clk);
            chk("t4_l_or_notc_car", 32'(l_or_notc), (i == 15) ? 32'd1 : 32'd0);
        end

        // 5: glitch rejection, then a 5-cycle pulse
        car_e_raw = 1'b0; s_IC = 2'b00;
        repeat (8) cyc();
        @(negedge clk);
        car_e_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            @(negedge clk);
            if (i == 2) car_e_raw = 1'b0;
            chk("t5_glitch_car", 32'(dut.car_q), 32'd0);
        end
        car_e_raw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            @(negedge clk);
            if (i == 5) car_e_raw = 1'b0;
            chk("t5_pulse_car", 32'(dut.car_q), (i >= 5 && i < 10) ? 32'd1 : 32'd0);
        end

        // 6: en_IC low ignores s_IC, counter saturates; then reset mid-phase
        s_IC = 2'b01;
        cyc();
        s_IC = 2'b00;
        cyc();
        en_IC = 1'b0;
        for (int i = 0; i < 300; i++) begin
            s_IC = 2'($urandom_range(0, 3));
            cyc();
        end
        @(negedge clk);
        chk("t6_sel_hold", 32'(dut.sel_q), 32'd0);
        chk("t6_cnt_sat", 32'(dut.cnt_q), 32'd255);
        chk("t6_en_s_sat", 32'(en_s), 32'd1);
        cyc();
        @(negedge clk);
        chk("t6_cnt_no_wrap", 32'(dut.cnt_q), 32'd255);
        rst = 1'b1; en_IC = 1'b1; s_IC = 2'b01;
        cyc();
        @(negedge clk);
        chk("t6_rst_sel", 32'(dut.sel_q), 32'd1);
        chk("t6_rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("t6_rst_flags", 32'({not_r, c_and_l, en_s, l_or_notc}), 32'd0);
        rst = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("t6_post_rst_not_r", 32'(not_r), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
